lcd_read_fsm: RTL and testbench

- Read-side companion to the LCD power-init and write sequencers in the LCD controller.
- Performs one 4-bit-mode HD44780 read transaction: RW=1, two E strobes, high nibble first, rebuilt into a byte.
- Supports busy-flag polling: repeats instruction-register reads until DB7=0 or a timeout expires.
- Instantiated inside the LCD controller. The controller owns the SF_D tristate and uses rd_active to release the bus.

---
 rtl/lcd_read_fsm_pkg.sv | 32 +++
 rtl/lcd_nibble_strobe.sv | 42 ++++
 rtl/lcd_read_fsm.sv | 152 +++++++++++++++
 tb/tb_lcd_read_fsm.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_read_fsm_pkg.sv
// Shared LCD controller definitions: default bus timing, busy-flag position and read-FSM encodings.
package lcd_read_fsm_pkg;

    localparam int unsigned T_SETUP_DEF  = 2;
    localparam int unsigned T_E_HIGH_DEF = 12;
    localparam int unsigned T_GAP_DEF    = 50;
    localparam int unsigned POLL_MAX_DEF = 100000;
    localparam int unsigned CNT_W_DEF    = 20;

    localparam int unsigned NIB_W   = 4;
    localparam int unsigned BYTE_W  = 8;
    // Busy flag DB7 sits in bit 3 of the high nibble.
    localparam int unsigned DB7_BIT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_UP_E,
        ST_UP_GAP,
        ST_LO_E,
        ST_LO_GAP,
        ST_CHECK
    } rd_state_t;

    typedef enum logic [1:0] {
        PH_NONE,
        PH_SETUP,
        PH_E_HIGH,
        PH_GAP
    } strobe_phase_t;

endpackage

// File: rtl/lcd_nibble_strobe.sv
// Phase timer for one LCD nibble strobe: flags the last cycle of setup/E-high/gap and the capture cycle.
module lcd_nibble_strobe
    import lcd_read_fsm_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_E_HIGH = T_E_HIGH_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  strobe_phase_t phase,
    output logic          last_c,
    output logic          capture_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] limit_c;

    always_comb begin
        limit_c = '0;
        case (phase)
            PH_SETUP:   limit_c = CNT_W'(T_SETUP - 1);
            PH_E_HIGH:  limit_c = CNT_W'(T_E_HIGH - 1);
            PH_GAP:     limit_c = CNT_W'(T_GAP - 1);
            default:    limit_c = '0;
        endcase
    end

    assign last_c    = (phase != PH_NONE) && (cnt_q == limit_c);
    assign capture_c = (phase == PH_E_HIGH) && last_c;

    // Every phase exits on its last cycle, so clearing there restarts the count for the next phase.
    always_ff @(posedge clk) begin
        if (reset || phase == PH_NONE || last_c) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/lcd_read_fsm.sv
// HD44780 4-bit read sequencer: two E strobes per byte, optional busy-flag polling with timeout.
module lcd_read_fsm
    import lcd_read_fsm_pkg::*;
#(
    parameter int unsigned T_SETUP  = T_SETUP_DEF,
    parameter int unsigned T_E_HIGH = T_E_HIGH_DEF,
    parameter int unsigned T_GAP    = T_GAP_DEF,
    parameter int unsigned POLL_MAX = POLL_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              rs_sel,
    input  logic              poll_busy,
    input  logic [NIB_W-1:0]  sf_d_in,
    output logic              ready,
    output logic              done,
    output logic [BYTE_W-1:0] data_out,
    output logic              timeout,
    output logic              rd_active,
    output logic              lcd_e,
    output logic              lcd_rw,
    output logic              lcd_rs
);

    localparam logic [CNT_W-1:0] POLL_LIM = CNT_W'(POLL_MAX);

    rd_state_t        state_q, state_d;
    strobe_phase_t    phase_c;
    logic             ph_last_c;
    logic             capture_c;
    logic [NIB_W-1:0] sf_q;
    logic [NIB_W-1:0] hi_q, hi_d;
    logic [NIB_W-1:0] lo_q, lo_d;
    logic             rs_q, rs_d;
    logic             poll_q, poll_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             finish_c;

    lcd_nibble_strobe #(
        .T_SETUP  (T_SETUP),
        .T_E_HIGH (T_E_HIGH),
        .T_GAP    (T_GAP),
        .CNT_W    (CNT_W)
    ) u_strobe (
        .clk       (clk),
        .reset     (reset),
        .phase     (phase_c),
        .last_c    (ph_last_c),
        .capture_c (capture_c)
    );

    // Next-state, nibble capture and poll-timeout bookkeeping.
    always_comb begin
        state_d  = state_q;
        phase_c  = PH_NONE;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rs_d     = rs_q;
        poll_d   = poll_q;
        tcnt_d   = tcnt_q;
        finish_c = 1'b0;

        if (state_q != ST_IDLE && tcnt_q < POLL_LIM) begin
            tcnt_d = tcnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    rs_d    = rs_sel;
                    poll_d  = poll_busy & ~rs_sel;
                    tcnt_d  = '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                phase_c = PH_SETUP;
                if (ph_last_c) state_d = ST_UP_E;
            end
            ST_UP_E: begin
                phase_c = PH_E_HIGH;
                if (capture_c) hi_d = sf_q;
                if (ph_last_c) state_d = ST_UP_GAP;
            end
            ST_UP_GAP: begin
                phase_c = PH_GAP;
                if (ph_last_c) state_d = ST_LO_E;
            end
            ST_LO_E: begin
                phase_c = PH_E_HIGH;
                if (capture_c) lo_d = sf_q;
                if (ph_last_c) state_d = ST_LO_GAP;
            end
            ST_LO_GAP: begin
                phase_c = PH_GAP;
                if (ph_last_c) state_d = ST_CHECK;
            end
            ST_CHECK: begin
                // done is already high here exactly when this byte ends the request.
                state_d = done ? ST_IDLE : ST_SETUP;
            end
            default: state_d = ST_IDLE;
        endcase

        // Decide on CHECK entry using the timeout count it will hold, so done can be registered.
        if (state_d == ST_CHECK && state_q != ST_CHECK) begin
            finish_c = ~(poll_q && hi_q[DB7_BIT] && tcnt_d < POLL_LIM);
        end
    end

    // State, captured data and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sf_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rs_q      <= 1'b0;
            poll_q    <= 1'b0;
            tcnt_q    <= '0;
            ready     <= 1'b1;
            done      <= 1'b0;
            data_out  <= '0;
            timeout   <= 1'b0;
            rd_active <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rw    <= 1'b0;
            lcd_rs    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sf_q      <= sf_d_in;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rs_q      <= rs_d;
            poll_q    <= poll_d;
            tcnt_q    <= tcnt_d;
            ready     <= (state_d == ST_IDLE);
            rd_active <= (state_d != ST_IDLE);
            lcd_rw    <= (state_d != ST_IDLE);
            lcd_e     <= (state_d == ST_UP_E) || (state_d == ST_LO_E);
            lcd_rs    <= rs_d;
            done      <= finish_c;
            if (finish_c) begin
                data_out <= {hi_q, lo_q};
                timeout  <= poll_q & hi_q[DB7_BIT];
            end
        end
    end

endmodule

// File: tb/tb_lcd_read_fsm.sv
// Bench for lcd_read_fsm: table vectors, randomized reads against a cycle-budget model, and corner sequences.
module tb_lcd_read_fsm;

    localparam int XACT_CYC = 2 + 2 * 12 + 2 * 50 + 1;

    logic       clk = 1'b0;
    logic       reset;
    logic       rs_sel;
    logic       poll_busy;
    logic       req_w   [2];
    logic [3:0] sf_w    [2];
    logic       ready_w [2];
    logic       done_w  [2];
    logic [7:0] data_w  [2];
    logic       to_w    [2];
    logic       act_w   [2];
    logic       e_w     [2];
    logic       rw_w    [2];
    logic       rs_w    [2];

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lcd_read_fsm u_dut (
        .clk(clk), .reset(reset), .req(req_w[0]), .rs_sel(rs_sel), .poll_busy(poll_busy),
        .sf_d_in(sf_w[0]), .ready(ready_w[0]), .done(done_w[0]), .data_out(data_w[0]),
        .timeout(to_w[0]), .rd_active(act_w[0]), .lcd_e(e_w[0]), .lcd_rw(rw_w[0]), .lcd_rs(rs_w[0])
    );

    lcd_read_fsm #(.POLL_MAX(300)) u_dut_to (
        .clk(clk), .reset(reset), .req(req_w[1]), .rs_sel(rs_sel), .poll_busy(poll_busy),
        .sf_d_in(sf_w[1]), .ready(ready_w[1]), .done(done_w[1]), .data_out(data_w[1]),
        .timeout(to_w[1]), .rd_active(act_w[1]), .lcd_e(e_w[1]), .lcd_rw(rw_w[1]), .lcd_rs(rs_w[1])
    );

    // LCD model: each E falling edge advances to the next nibble of the scripted response bytes.
    logic [7:0] resp     [2][4];
    int         resp_n   [2];
    int         nib      [2];
    int         nib_base [2];
    logic       prev_e   [2];

    function automatic logic [3:0] model_nibble(input int i);
        int k;
        int bi;
        logic [7:0] b;
        if (resp_n[i] == 0) return 4'h0;
        k  = nib[i] - nib_base[i];
        bi = k / 2;
        if (bi >= resp_n[i]) bi = resp_n[i] - 1;
        b = resp[i][bi];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (prev_e[i] === 1'b1 && e_w[i] === 1'b0) nib[i] = nib[i] + 1;
            prev_e[i] = e_w[i];
            sf_w[i]   = model_nibble(i);
        end
    end

    task automatic load(input int s, input logic [31:0] b, input int n);
        for (int i = 0; i < 4; i++) resp[s][i] = b[31-8*i -: 8];
        resp_n[s]   = n;
        nib_base[s] = nib[s];
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference: a read of byte i reaches CHECK after 127*(i+1) cycles; the poll count saturates at the limit.
    function automatic void ref_read(input int s, input logic rs, input logic pb, input logic [31:0] b,
                                     input int n, output logic [7:0] d, output logic to, output int x);
        int pm;
        int cnt;
        logic polling;
        logic [7:0] cur;
        pm = (s == 1) ? 300 : 100000;
        polling = pb && !rs;
        d = 8'h00; to = 1'b0; x = 0;
        for (int i = 0; i < 1000; i++) begin
            cur = b[31-8*((i < n) ? i : n - 1) -: 8];
            cnt = XACT_CYC * (i + 1) - 1;
            if (cnt > pm) cnt = pm;
            if (!(polling && cur[7] && cnt < pm)) begin
                d = cur; to = polling && cur[7]; x = i + 1;
                break;
            end
        end
    endfunction

    task automatic run_read(input int s, input logic rs, input logic pb, input logic [7:0] exp_d,
                            input logic exp_to, input int exp_x, input string nm);
        int c;
        int run;
        int strobes;
        int bad_e;
        int bad_ctl;
        c = 0; run = 0; strobes = 0; bad_e = 0; bad_ctl = 0;
        rs_sel = rs; poll_busy = pb;
        chk({nm, ".ready_before"}, 32'(ready_w[s]), 32'd1);
        req_w[s] = 1'b1;
        @(negedge clk);
        req_w[s] = 1'b0;
        rs_sel = ~rs; poll_busy = ~pb;
        c = 1;
        while (c <= XACT_CYC * exp_x + 20) begin
            if (done_w[s]) break;
            if (e_w[s]) begin
                run++;
                if (!(rw_w[s] && rs_w[s] == rs && act_w[s])) bad_ctl++;
            end else if (run != 0) begin
                if (run != 12) bad_e++;
                strobes++;
                run = 0;
            end
            @(negedge clk);
            c++;
        end
        chk({nm, ".done_cycle"}, 32'(c), 32'(XACT_CYC * exp_x));
        chk({nm, ".data"}, 32'(data_w[s]), 32'(exp_d));
        chk({nm, ".timeout"}, 32'(to_w[s]), 32'(exp_to));
        chk({nm, ".strobes"}, 32'(strobes), 32'(2 * exp_x));
        chk({nm, ".e_width_bad"}, 32'(bad_e), 32'd0);
        chk({nm, ".ctl_bad"}, 32'(bad_ctl), 32'd0);
        chk({nm, ".rs_at_done"}, 32'(rs_w[s]), 32'(rs));
        @(negedge clk);
        chk({nm, ".done_single"}, 32'(done_w[s]), 32'd0);
        chk({nm, ".ready_after"}, 32'(ready_w[s]), 32'd1);
        chk({nm, ".rw_after"}, 32'(rw_w[s]), 32'd0);
        chk({nm, ".act_after"}, 32'(act_w[s]), 32'd0);
    endtask

    typedef struct {
        int          s;
        logic        rs;
        logic        pb;
        int          n;
        logic [31:0] b;
        logic [7:0]  d;
        logic        to;
        int          x;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int c;
        int pulses;
        logic [31:0] rb;
        logic [7:0] ed;
        logic eto;
        int ex;
        int s;
        int n;
        logic rs;
        logic pb;

        tbl[0] = '{s: 0, rs: 1'b1, pb: 1'b0, n: 1, b: 32'hA5000000, d: 8'hA5, to: 1'b0, x: 1};
        tbl[1] = '{s: 0, rs: 1'b0, pb: 1'b1, n: 4, b: 32'h83838305, d: 8'h05, to: 1'b0, x: 4};
        tbl[2] = '{s: 1, rs: 1'b0, pb: 1'b1, n: 1, b: 32'h80000000, d: 8'h80, to: 1'b1, x: 3};
        tbl[3] = '{s: 0, rs: 1'b1, pb: 1'b1, n: 1, b: 32'hFF000000, d: 8'hFF, to: 1'b0, x: 1};
        tbl[4] = '{s: 0, rs: 1'b0, pb: 1'b0, n: 1, b: 32'h83000000, d: 8'h83, to: 1'b0, x: 1};
        tbl[5] = '{s: 1, rs: 1'b0, pb: 1'b1, n: 2, b: 32'h83050000, d: 8'h05, to: 1'b0, x: 2};

        for (int i = 0; i < 2; i++) begin
            req_w[i] = 1'b0; resp_n[i] = 0; nib[i] = 0; nib_base[i] = 0; prev_e[i] = 1'b0;
        end
        reset = 1'b1; rs_sel = 1'b0; poll_busy = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset.ready", 32'(ready_w[i]), 32'd1);
            chk("reset.done", 32'(done_w[i]), 32'd0);
            chk("reset.e_rw_rs", {29'd0, e_w[i], rw_w[i], rs_w[i]}, 32'd0);
            chk("reset.act_to", {30'd0, act_w[i], to_w[i]}, 32'd0);
            chk("reset.data", 32'(data_w[i]), 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            load(tbl[i].s, tbl[i].b, tbl[i].n);
            run_read(tbl[i].s, tbl[i].rs, tbl[i].pb, tbl[i].d, tbl[i].to, tbl[i].x, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 10; i++) begin
            s  = int'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            pb = 1'($urandom_range(0, 1));
            n  = int'($urandom_range(1, 4));
            rb = $urandom;
            // Keep long-limit polls finite: the last scripted byte reports not-busy.
            if (s == 0) rb[31-8*(n-1)] = 1'b0;
            ref_read(s, rs, pb, rb, n, ed, eto, ex);
            load(s, rb, n);
            run_read(s, rs, pb, ed, eto, ex, $sformatf("rnd%0d", i));
        end

        // Reset asserted in the fifth E-high cycle of the first strobe.
        load(0, 32'hA5000000, 1);
        rs_sel = 1'b1; poll_busy = 1'b0;
        req_w[0] = 1'b1;
        @(negedge clk);
        req_w[0] = 1'b0;
        c = 1;
        while (c < 7) begin @(negedge clk); c++; end
        chk("rst_mid.e_before", 32'(e_w[0]), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid.e", 32'(e_w[0]), 32'd0);
        chk("rst_mid.rw", 32'(rw_w[0]), 32'd0);
        chk("rst_mid.act", 32'(act_w[0]), 32'd0);
        chk("rst_mid.ready", 32'(ready_w[0]), 32'd1);
        reset = 1'b0;
        pulses = 0;
        repeat (300) begin
            if (done_w[0]) pulses++;
            @(negedge clk);
        end
        chk("rst_mid.no_done", 32'(pulses), 32'd0);
        chk("rst_mid.data", 32'(data_w[0]), 32'd0);

        // Requests during UP_GAP and in the done cycle are dropped; the next cycle's request starts a read.
        load(0, 32'h3CC30000, 2);
        rs_sel = 1'b1;
        req_w[0] = 1'b1;
        @(negedge clk);
        req_w[0] = 1'b0;
        c = 1;
        pulses = 0;
        while (c < 400) begin
            if (done_w[0]) break;
            if (c == 20) req_w[0] = 1'b1;
            if (c == 21) req_w[0] = 1'b0;
            @(negedge clk);
            c++;
        end
        chk("busy.done_cycle", 32'(c), 32'(XACT_CYC));
        chk("busy.data", 32'(data_w[0]), 32'h3C);
        req_w[0] = 1'b1;
        @(negedge clk);
        chk("busy.ready_after_done", 32'(ready_w[0]), 32'd1);
        chk("busy.idle_after_done", 32'(act_w[0]), 32'd0);
        @(negedge clk);
        req_w[0] = 1'b0;
        c = 129;
        chk("busy.setup_act", 32'(act_w[0]), 32'd1);
        chk("busy.setup_e_rw", {30'd0, e_w[0], rw_w[0]}, 32'd1);
        while (c < 600) begin
            if (done_w[0]) break;
            @(negedge clk);
            c++;
        end
        chk("busy.second_done", 32'(c), 32'(128 + XACT_CYC));
        chk("busy.second_data", 32'(data_w[0]), 32'hC3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
